// File: rtl/mips_pkg.sv
// Shared MIPS pipeline constants: next-PC source encoding, NOP word, kernel vectors,
// fetch FSM states and the bit-31-preserving PC increment.
package mips_pkg;

    localparam logic [2:0] PCSRC_SEQ = 3'b000;
    localparam logic [2:0] PCSRC_BR  = 3'b001;
    localparam logic [2:0] PCSRC_J   = 3'b010;
    localparam logic [2:0] PCSRC_JR  = 3'b011;

    localparam logic [31:0] NOP = 32'h0000_0000;

    localparam logic [31:0] RESET_PC_DEF = 32'h8000_0000;
    localparam logic [31:0] IRQ_VEC_DEF  = 32'h8000_0004;
    localparam logic [31:0] EXC_VEC_DEF  = 32'h8000_0008;

    typedef enum logic [0:0] {
        StBoot,
        StRun
    } if_state_e;

    // The increment wraps inside the low 31 bits so the kernel-mode bit is untouched.
    function automatic logic [31:0] pc_inc(input logic [31:0] pc);
        return {pc[31], pc[30:0] + 31'd4};
    endfunction

endpackage

// File: rtl/if_stage_if.sv
// Fetch-stage signal bundle: hazard/ID controls, instruction memory and IF/ID outputs.
interface if_stage_if;
    logic        pc_write;
    logic        if_flush;
    logic        ifid_write;
    logic [2:0]  id_pcsrc;
    logic        id_branch_taken;
    logic [31:0] id_branch_target;
    logic [25:0] id_jump_index;
    logic [31:0] id_jr_target;
    logic        id_exc;
    logic        irq;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] pc_out;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc_plus4;
    logic        ifid_valid;
    logic        irq_ack;
    logic [31:0] epc;

    modport master (
        output pc_write, if_flush, ifid_write, id_pcsrc, id_branch_taken, id_branch_target,
               id_jump_index, id_jr_target, id_exc, irq, imem_rdata,
        input  imem_addr, pc_out, ifid_instr, ifid_pc_plus4, ifid_valid, irq_ack, epc
    );

    modport slave (
        input  pc_write, if_flush, ifid_write, id_pcsrc, id_branch_taken, id_branch_target,
               id_jump_index, id_jr_target, id_exc, irq, imem_rdata,
        output imem_addr, pc_out, ifid_instr, ifid_pc_plus4, ifid_valid, irq_ack, epc
    );
endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: NOP load, flush (keeps PC+4 of the squashed fetch) and hold.
module if_id_reg
    import mips_pkg::*;
(
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        nop_i,
    input  logic        flush_i,
    input  logic        write_i,
    input  logic [31:0] instr_i,
    input  logic [31:0] pc_plus4_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_plus4_o,
    output logic        valid_o
);
    logic [31:0] instr_q;
    logic [31:0] pc_plus4_q;
    logic        valid_q;

    always_ff @(posedge clk_i) begin
        if (reset_i || nop_i) begin
            instr_q    <= NOP;
            pc_plus4_q <= 32'h0;
            valid_q    <= 1'b0;
        end else if (flush_i) begin
            instr_q    <= NOP;
            pc_plus4_q <= pc_plus4_i;
            valid_q    <= 1'b0;
        end else if (write_i) begin
            instr_q    <= instr_i;
            pc_plus4_q <= pc_plus4_i;
            valid_q    <= 1'b1;
        end
    end

    assign instr_o    = instr_q;
    assign pc_plus4_o = pc_plus4_q;
    assign valid_o    = valid_q;
endmodule

// File: rtl/if_stage.sv
// MIPS fetch stage: PC register, next-PC selection with exception/interrupt redirect,
// and the IF/ID register.
module if_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter logic [31:0] IRQ_VEC  = IRQ_VEC_DEF,
    parameter logic [31:0] EXC_VEC  = EXC_VEC_DEF
) (
    input logic        clk,
    input logic        reset,
    if_stage_if.slave  bus
);
    if_state_e   state_q;
    logic [31:0] pc_q, pc_d;
    logic [31:0] epc_q, epc_d;
    logic        irq_pend_q;
    logic        irq_ack_q;
    logic [31:0] pc_plus4;
    logic        id_redirect;
    logic        exc_take;
    logic        irq_take;

    assign pc_plus4    = pc_inc(pc_q);
    assign id_redirect = (bus.id_pcsrc == PCSRC_BR && bus.id_branch_taken) ||
                         (bus.id_pcsrc == PCSRC_J) || (bus.id_pcsrc == PCSRC_JR);
    assign exc_take    = (state_q == StRun) && bus.id_exc && bus.pc_write;
    // Interrupts wait out kernel mode, stalls and any pending ID redirect.
    assign irq_take    = (state_q == StRun) && irq_pend_q && !pc_q[31] && bus.pc_write &&
                         !id_redirect && !bus.id_exc;

    always_comb begin
        pc_d  = pc_q;
        epc_d = epc_q;
        if (state_q == StBoot) begin
            pc_d = pc_q;
        end else if (exc_take) begin
            pc_d  = EXC_VEC;
            epc_d = bus.ifid_pc_plus4 - 32'd4;
        end else if (irq_take) begin
            pc_d  = IRQ_VEC;
            epc_d = pc_q;
        end else if (bus.pc_write) begin
            case (bus.id_pcsrc)
                PCSRC_BR: pc_d = bus.id_branch_taken ? bus.id_branch_target : pc_plus4;
                PCSRC_J:  pc_d = {pc_q[31], bus.ifid_pc_plus4[30:28], bus.id_jump_index, 2'b00};
                PCSRC_JR: pc_d = bus.id_jr_target;
                default:  pc_d = pc_plus4;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StBoot;
            pc_q       <= RESET_PC;
            epc_q      <= 32'h0;
            irq_pend_q <= 1'b0;
            irq_ack_q  <= 1'b0;
        end else begin
            state_q    <= StRun;
            pc_q       <= pc_d;
            epc_q      <= epc_d;
            irq_pend_q <= (irq_pend_q && !irq_take) || bus.irq;
            irq_ack_q  <= irq_take;
        end
    end

    if_id_reg u_if_id_reg (
        .clk_i      (clk),
        .reset_i    (reset),
        .nop_i      (state_q == StBoot),
        .flush_i    (bus.if_flush || bus.id_exc || irq_take),
        .write_i    (bus.ifid_write),
        .instr_i    (bus.imem_rdata),
        .pc_plus4_i (pc_plus4),
        .instr_o    (bus.ifid_instr),
        .pc_plus4_o (bus.ifid_pc_plus4),
        .valid_o    (bus.ifid_valid)
    );

    assign bus.imem_addr = {1'b0, pc_q[30:0]};
    assign bus.pc_out    = pc_q;
    assign bus.irq_ack   = irq_ack_q;
    assign bus.epc       = epc_q;
endmodule

// File: tb/tb_if_stage.sv
// Table-driven bench for if_stage: per-cycle stimulus records with expected post-edge state,
// expectations queued on drive and popped after the edge.
module tb_if_stage;
    logic clk = 1'b0;
    logic reset;
    int   tests = 0;
    int   fails = 0;

    if_stage_if bus ();

    if_stage dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // ROM model: each word holds its own address plus one.
    assign bus.imem_rdata = bus.imem_addr + 32'd1;

    typedef struct {
        logic        rst, pw, fl, iw;
        logic [2:0]  src;
        logic        tk;
        logic [31:0] tgt;
        logic [25:0] jdx;
        logic [31:0] jr;
        logic        exc, irq;
    } stim_t;

    typedef struct {
        logic [31:0] pc, ins, p4;
        logic        vld, ack;
        logic [31:0] epc;
    } exp_t;

    typedef struct {
        stim_t s;
        exp_t  e;
    } vec_t;

    vec_t vecs[$];
    exp_t sb[$];

    function automatic stim_t sd();
        stim_t s;
        s = '{default: '0};
        s.pw = 1'b1;
        s.iw = 1'b1;
        return s;
    endfunction

    function automatic stim_t s_irq();
        stim_t s = sd();
        s.irq = 1'b1;
        return s;
    endfunction

    function automatic stim_t s_jr(input logic [31:0] a);
        stim_t s = sd();
        s.src = 3'b011; s.jr = a; s.fl = 1'b1;
        return s;
    endfunction

    function automatic stim_t s_br(input logic tk, input logic [31:0] t);
        stim_t s = sd();
        s.src = 3'b001; s.tk = tk; s.tgt = t; s.fl = tk;
        return s;
    endfunction

    function automatic stim_t s_j(input logic [25:0] idx);
        stim_t s = sd();
        s.src = 3'b010; s.jdx = idx; s.fl = 1'b1;
        return s;
    endfunction

    function automatic stim_t s_mod(input int kind);
        stim_t s = sd();
        case (kind)
            0: begin s.pw = 1'b0; s.fl = 1'b1; end   // load-use bubble
            1: s.iw = 1'b0;                           // IF/ID hold
            2: s.exc = 1'b1;
            default: s.rst = 1'b1;
        endcase
        return s;
    endfunction

    task automatic add(input stim_t s, input logic [31:0] pc, input logic [31:0] ins,
                       input logic [31:0] p4, input logic vld, input logic ack,
                       input logic [31:0] epc);
        vec_t v;
        v.s = s;
        v.e = '{pc: pc, ins: ins, p4: p4, vld: vld, ack: ack, epc: epc};
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input int idx, input logic [31:0] act,
                       input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s [vec %0d]: got %h, expected %h", nm, idx, act, req);
        end
    endtask

    task automatic drive(input stim_t s);
        reset                = s.rst;
        bus.pc_write         = s.pw;
        bus.if_flush         = s.fl;
        bus.ifid_write       = s.iw;
        bus.id_pcsrc         = s.src;
        bus.id_branch_taken  = s.tk;
        bus.id_branch_target = s.tgt;
        bus.id_jump_index    = s.jdx;
        bus.id_jr_target     = s.jr;
        bus.id_exc           = s.exc;
        bus.irq              = s.irq;
    endtask

    task automatic check_all(input int idx, input exp_t e);
        chk("pc",         idx, bus.pc_out,        e.pc);
        chk("imem_addr",  idx, bus.imem_addr,     {1'b0, e.pc[30:0]});
        chk("ifid_instr", idx, bus.ifid_instr,    e.ins);
        chk("ifid_pc+4",  idx, bus.ifid_pc_plus4, e.p4);
        chk("ifid_valid", idx, {31'b0, bus.ifid_valid}, {31'b0, e.vld});
        chk("irq_ack",    idx, {31'b0, bus.irq_ack},    {31'b0, e.ack});
        chk("epc",        idx, bus.epc,           e.epc);
    endtask

    initial begin
        exp_t e;
        // Boot and sequential fetch from the reset vector
        add(sd(),              32'h8000_0000, 32'h0,          32'h0,         0, 0, 32'h0);
        add(sd(),              32'h8000_0004, 32'h1,          32'h8000_0004, 1, 0, 32'h0);
        add(sd(),              32'h8000_0008, 32'h5,          32'h8000_0008, 1, 0, 32'h0);
        // jr into user space, bubble, branches, jump
        add(s_jr(32'h10),      32'h0000_0010, 32'h0,          32'h8000_000C, 0, 0, 32'h0);
        add(s_mod(0),          32'h0000_0010, 32'h0,          32'h0000_0014, 0, 0, 32'h0);
        add(sd(),              32'h0000_0014, 32'h11,         32'h0000_0014, 1, 0, 32'h0);
        add(s_br(1, 32'h40),   32'h0000_0040, 32'h0,          32'h0000_0018, 0, 0, 32'h0);
        add(s_br(0, 32'h100),  32'h0000_0044, 32'h41,         32'h0000_0044, 1, 0, 32'h0);
        add(s_j(26'd7),        32'h0000_001C, 32'h0,          32'h0000_0048, 0, 0, 32'h0);
        // User-mode interrupt: pending at pc 0x20, taken there
        add(s_irq(),           32'h0000_0020, 32'h1D,         32'h0000_0020, 1, 0, 32'h0);
        add(sd(),              32'h8000_0004, 32'h0,          32'h0000_0024, 0, 1, 32'h20);
        add(sd(),              32'h8000_0008, 32'h5,          32'h8000_0008, 1, 0, 32'h20);
        // Kernel-mode interrupt deferred until the first user-mode fetch
        add(s_jr(32'h8000_0100), 32'h8000_0100, 32'h0,        32'h8000_000C, 0, 0, 32'h20);
        add(s_irq(),           32'h8000_0104, 32'h101,        32'h8000_0104, 1, 0, 32'h20);
        add(sd(),              32'h8000_0108, 32'h105,        32'h8000_0108, 1, 0, 32'h20);
        add(s_jr(32'h24),      32'h0000_0024, 32'h0,          32'h8000_010C, 0, 0, 32'h20);
        add(sd(),              32'h8000_0004, 32'h0,          32'h0000_0028, 0, 1, 32'h24);
        // Exception beats a pending interrupt, which survives it
        add(s_jr(32'h2C),      32'h0000_002C, 32'h0,          32'h8000_0008, 0, 0, 32'h24);
        add(s_irq(),           32'h0000_0030, 32'h2D,         32'h0000_0030, 1, 0, 32'h24);
        add(s_mod(2),          32'h8000_0008, 32'h0,          32'h0000_0034, 0, 0, 32'h2C);
        add(sd(),              32'h8000_000C, 32'h9,          32'h8000_000C, 1, 0, 32'h2C);
        add(s_jr(32'h50),      32'h0000_0050, 32'h0,          32'h8000_0010, 0, 0, 32'h2C);
        add(sd(),              32'h8000_0004, 32'h0,          32'h0000_0054, 0, 1, 32'h50);
        // IF/ID hold, then PC+4 wrap inside 31 bits
        add(sd(),              32'h8000_0008, 32'h5,          32'h8000_0008, 1, 0, 32'h50);
        add(s_mod(1),          32'h8000_000C, 32'h5,          32'h8000_0008, 1, 0, 32'h50);
        add(s_jr(32'h7FFF_FFFC), 32'h7FFF_FFFC, 32'h0,        32'h8000_0010, 0, 0, 32'h50);
        add(sd(),              32'h0000_0000, 32'h7FFF_FFFD,  32'h0000_0000, 1, 0, 32'h50);
        // Take an interrupt with irq still high, then reset: ack and pending irq discarded
        add(s_irq(),           32'h0000_0004, 32'h1,          32'h0000_0004, 1, 0, 32'h50);
        add(s_irq(),           32'h8000_0004, 32'h0,          32'h0000_0008, 0, 1, 32'h4);
        add(s_mod(3),          32'h8000_0000, 32'h0,          32'h0,         0, 0, 32'h0);
        add(sd(),              32'h8000_0000, 32'h0,          32'h0,         0, 0, 32'h0);
        add(s_jr(32'h60),      32'h0000_0060, 32'h0,          32'h8000_0004, 0, 0, 32'h0);
        add(sd(),              32'h0000_0064, 32'h61,         32'h0000_0064, 1, 0, 32'h0);

        // Hand sequence: two reset cycles, then reset values
        drive(sd());
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_all(-1, '{pc: 32'h8000_0000, ins: 32'h0, p4: 32'h0, vld: 1'b0, ack: 1'b0,
                        epc: 32'h0});

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].s);
            sb.push_back(vecs[i].e);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            check_all(i, e);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete, got no finish, expected finish");
        $fatal(1);
    end
endmodule
